register_dump_unit: RTL and testbench

Debug-path sequencer that sits between the register file's debug read port and the UART transmitter. On a start request it drives the register file into debug mode and walks register addresses 0 to NUM_REGS-1. It captures each 32-bit value and streams it as bytes, MSB first, over a valid/ready byte interface, preceded by one header byte. The processor pipeline must be halted by the debug controller before `start` is issued.

---
 rtl/debug_pkg.sv | 18 +
 rtl/register_dump_unit.sv | 101 ++++++++++
 tb/tb_register_dump_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared debug-path constants: state encoding, header byte, byte framing and
// debug address width.
package debug_pkg;

  localparam int unsigned ADDR_W        = 5;
  localparam int unsigned BYTES_PER_REG = 4;
  localparam int unsigned CNT_W         = 2;
  localparam int unsigned DATA_W        = 32;

  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HEADER  = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/register_dump_unit.sv
// Walks the register file's debug read port and streams a header byte followed
// by every register, MSB first, over a valid/ready byte interface.
module register_dump_unit
  import debug_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 32,
  parameter logic [7:0]  HEADER_BYTE = HEADER_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] reg_data_in,
  input  logic              tx_ready,
  output logic              debug_on,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              busy,
  output logic              done
);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [CNT_W-1:0]  byte_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              hs_c;
  logic              last_byte_c;
  logic              last_reg_c;

  assign hs_c        = tx_valid & tx_ready;
  assign last_byte_c = (byte_cnt == CNT_W'(BYTES_PER_REG - 1));
  assign last_reg_c  = (reg_addr == ADDR_W'(NUM_REGS - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_HEADER;
      ST_HEADER:  if (hs_c) state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: state_nxt = ST_SEND;
      ST_SEND: begin
        if (hs_c && last_byte_c) begin
          state_nxt = last_reg_c ? ST_DONE : ST_RD_WAIT;
        end
      end
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Address walker, byte shifter and byte counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_addr  <= '0;
      shift_reg <= '0;
      byte_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            reg_addr <= '0;
            byte_cnt <= '0;
          end
        end
        ST_RD_WAIT: begin
          shift_reg <= reg_data_in;
          byte_cnt  <= '0;
        end
        ST_SEND: begin
          if (hs_c) begin
            shift_reg <= shift_reg << 8;
            byte_cnt  <= byte_cnt + CNT_W'(1);
            if (last_byte_c && !last_reg_c) begin
              reg_addr <= reg_addr + ADDR_W'(1);
            end
          end
        end
        ST_DONE:  reg_addr <= '0;
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only; tx_ready never reaches them
  assign debug_on = (state != ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign tx_valid = (state == ST_HEADER) || (state == ST_SEND);
  assign tx_data  = (state == ST_HEADER) ? HEADER_BYTE :
                    (state == ST_SEND)   ? shift_reg[DATA_W-1 -: 8] : 8'h00;

endmodule

// File: tb/tb_register_dump_unit.sv
// Randomized bench for register_dump_unit: byte streams are checked against a
// queue built directly from the register contents.
module tb_register_dump_unit;
  import debug_pkg::*;

  localparam int unsigned NA = 32;
  localparam int unsigned NB = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_a, start_b, tx_ready;
  logic [31:0]       regs [32];
  logic [31:0]       rd_a, rd_b;
  logic              debug_on_a, tx_valid_a, busy_a, done_a;
  logic              debug_on_b, tx_valid_b, busy_b, done_b;
  logic [ADDR_W-1:0] reg_addr_a, reg_addr_b;
  logic [7:0]        tx_data_a, tx_data_b;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          c0 = 0;
  int unsigned rdy_pct = 100;
  logic [7:0]  got_a[$], got_b[$], exp_q[$];
  int          done_cyc_a[$];
  int          done_cnt_a = 0, done_cnt_b = 0, done_cyc_b = 0;
  logic [ADDR_W-1:0] last_addr_b = '0;
  bit          stall_a = 0, prev_done_a = 0;
  logic [7:0]  held_a = 8'h00;

  register_dump_unit #(.NUM_REGS(NA)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .reg_data_in(rd_a), .tx_ready(tx_ready),
    .debug_on(debug_on_a), .reg_addr(reg_addr_a), .tx_data(tx_data_a),
    .tx_valid(tx_valid_a), .busy(busy_a), .done(done_a)
  );

  register_dump_unit #(.NUM_REGS(NB)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .reg_data_in(rd_b), .tx_ready(tx_ready),
    .debug_on(debug_on_b), .reg_addr(reg_addr_b), .tx_data(tx_data_b),
    .tx_valid(tx_valid_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file debug port: read completes on the falling edge
  always @(negedge clk) begin
    rd_a <= regs[reg_addr_a];
    rd_b <= regs[reg_addr_b];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference stream: header, then each register MSB first, repeated per dump
  task automatic build_exp(input int n, input int reps);
    exp_q.delete();
    repeat (reps) begin
      exp_q.push_back(8'hA5);
      for (int r = 0; r < n; r++)
        for (int b = 3; b >= 0; b--) exp_q.push_back(regs[r][8*b +: 8]);
    end
  endtask

  task automatic cmp_stream(input string tag, input bit use_b);
    int n;
    n = use_b ? got_b.size() : got_a.size();
    chk({tag, "_len"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk(tag, 64'(use_b ? got_b[i] : got_a[i]), 64'(exp_q[i]));
  endtask

  // Drives tx_ready, then samples outputs 1ns after the falling edge
  always @(negedge clk) begin
    tx_ready = ($urandom_range(99) < rdy_pct);
    #1;
    if (rst) begin
      stall_a     = 1'b0;
      prev_done_a = 1'b0;
    end else begin
      if (stall_a) chk("hold", 64'({tx_valid_a, tx_data_a}), 64'({1'b1, held_a}));
      if (prev_done_a) chk("idle_after_done", 64'(busy_a), 64'(0));
      if (tx_valid_a && tx_ready) got_a.push_back(tx_data_a);
      stall_a = tx_valid_a && !tx_ready;
      held_a  = tx_data_a;
      if (done_a) begin
        done_cnt_a++;
        done_cyc_a.push_back(cyc);
      end
      prev_done_a = done_a;
      if (tx_valid_b && tx_ready) begin
        got_b.push_back(tx_data_b);
        last_addr_b = reg_addr_b;
      end
      if (done_b) begin
        done_cnt_b++;
        done_cyc_b = cyc;
      end
    end
  end

  task automatic pulse_a();
    @(negedge clk);
    start_a = 1'b1;
    c0 = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int target);
    int i;
    i = 0;
    while (done_cnt_a < target && i < 5000) begin
      @(negedge clk);
      i++;
    end
    chk("done_timeout", 64'(done_cnt_a >= target), 64'(1));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int dc;
    int i;
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; tx_ready = 1'b1;
    for (int r = 0; r < 32; r++) regs[r] = $urandom();
    regs[0] = 32'h0000_0001; regs[8] = 32'h0000_0004; regs[31] = 32'd42;
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", 64'(busy_a), 64'(0));
    chk("rst_valid", 64'(tx_valid_a), 64'(0));
    chk("rst_debug_on", 64'(debug_on_a), 64'(0));
    chk("rst_done", 64'(done_a), 64'(0));
    chk("rst_addr", 64'(reg_addr_a), 64'(0));
    chk("rst_data", 64'(tx_data_a), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Full dump, no back-pressure
    build_exp(NA, 1);
    got_a.delete(); done_cyc_a.delete(); dc = done_cnt_a;
    pulse_a();
    wait_done_a(dc + 1);
    cmp_stream("full", 0);
    if (got_a.size() > 36)
      chk("reg8_bytes", 64'({got_a[33], got_a[34], got_a[35], got_a[36]}), 64'(32'h4));
    if (done_cyc_a.size() > 0) chk("done_edge", 64'(done_cyc_a[0] - c0), 64'(161));

    // Reset mid-SEND at register 7, byte 2
    got_a.delete();
    pulse_a();
    i = 0;
    while (got_a.size() < 31 && i < 1000) begin
      @(negedge clk);
      i++;
    end
    chk("pre_rst_addr", 64'(reg_addr_a), 64'(7));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_debug_on", 64'(debug_on_a), 64'(0));
    chk("mid_rst_valid", 64'(tx_valid_a), 64'(0));
    chk("mid_rst_busy", 64'(busy_a), 64'(0));
    chk("mid_rst_addr", 64'(reg_addr_a), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    got_a.delete(); dc = done_cnt_a;
    pulse_a();
    wait_done_a(dc + 1);
    cmp_stream("after_rst", 0);

    // Random back-pressure
    rdy_pct = 30;
    got_a.delete(); dc = done_cnt_a;
    pulse_a();
    wait_done_a(dc + 1);
    cmp_stream("bp", 0);
    rdy_pct = 100;

    // Start pulse while busy is ignored
    got_a.delete(); dc = done_cnt_a;
    pulse_a();
    repeat (48) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a(dc + 1);
    repeat (20) @(negedge clk);
    chk("busy_start_once", 64'(done_cnt_a), 64'(dc + 1));
    chk("busy_start_idle", 64'(busy_a), 64'(0));
    cmp_stream("busy_start", 0);

    // Held start: back-to-back dumps with one idle cycle between
    build_exp(NA, 2);
    got_a.delete(); done_cyc_a.delete(); dc = done_cnt_a;
    @(negedge clk);
    start_a = 1'b1;
    c0 = cyc + 1;
    repeat (300) @(negedge clk);
    start_a = 1'b0;
    wait_done_a(dc + 2);
    cmp_stream("held", 0);
    if (done_cyc_a.size() > 1) begin
      chk("held_done0", 64'(done_cyc_a[0] - c0), 64'(161));
      chk("held_gap", 64'(done_cyc_a[1] - done_cyc_a[0]), 64'(163));
    end

    // Four-register instance
    build_exp(NB, 1);
    got_b.delete(); dc = done_cnt_b;
    @(negedge clk);
    start_b = 1'b1;
    c0 = cyc + 1;
    @(negedge clk);
    start_b = 1'b0;
    i = 0;
    while (done_cnt_b <= dc && i < 1000) begin
      @(negedge clk);
      i++;
    end
    chk("nb4_done_timeout", 64'(done_cnt_b > dc), 64'(1));
    repeat (3) @(negedge clk);
    cmp_stream("nb4", 1);
    chk("nb4_last_addr", 64'(last_addr_b), 64'(3));
    chk("nb4_done_edge", 64'(done_cyc_b - c0), 64'(21));
    chk("nb4_idle", 64'(busy_b), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
